// File: rtl/multiplier.sv
// Iterative 32x32->64 shift-add multiplier (signed/unsigned) with level-held mul/complete handshake.
// Optional build macro MUL_EARLY_OUT_EN: leave CALC as soon as the remaining multiplier bits are zero.
module multiplier (
  input  logic        mul_clk,
  input  logic        resetn,
  input  logic        mul,
  input  logic        mul_signed,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [63:0] result,
  output logic        complete
);

  localparam int unsigned OP_W  = 32;
  localparam int unsigned RES_W = 64;
  localparam int unsigned CNT_W = 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [CNT_W-1:0] count;
  logic [RES_W-1:0] mcand;
  logic [RES_W-1:0] acc;
  logic [OP_W-1:0]  mplier;
  logic             neg;

  logic [OP_W-1:0]  abs_x_c;
  logic [OP_W-1:0]  abs_y_c;
  logic [OP_W-1:0]  mplier_shift_c;
  logic             calc_last_c;

  // Operand magnitudes; -2^31 maps to 0x80000000 as an unsigned value
  always_comb begin
    abs_x_c = (mul_signed && x[OP_W-1]) ? (~x + OP_W'(1)) : x;
    abs_y_c = (mul_signed && y[OP_W-1]) ? (~y + OP_W'(1)) : y;
  end

  always_comb begin
    mplier_shift_c = mplier >> 1;
`ifdef MUL_EARLY_OUT_EN
    calc_last_c = (count == CNT_W'(OP_W - 1)) || (mplier_shift_c == '0);
`else
    calc_last_c = (count == CNT_W'(OP_W - 1));
`endif
  end

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  // Next state; dropping mul in CALC or FIX aborts without touching result
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (mul) next_state = S_CALC;
      S_CALC: begin
        if (!mul)             next_state = S_IDLE;
        else if (calc_last_c) next_state = S_FIX;
      end
      S_FIX:  next_state = mul ? S_DONE : S_IDLE;
      S_DONE: if (!mul) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      count    <= '0;
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      neg      <= 1'b0;
      result   <= '0;
      complete <= 1'b0;
    end else begin
      complete <= (next_state == S_DONE);
      if (state == S_IDLE && mul) begin
        mcand  <= RES_W'(abs_x_c);
        mplier <= abs_y_c;
        acc    <= '0;
        count  <= '0;
        neg    <= mul_signed & (x[OP_W-1] ^ y[OP_W-1]);
      end else if (state == S_CALC && mul) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier_shift_c;
        count  <= count + CNT_W'(1);
      end else if (state == S_FIX && mul) begin
        result <= neg ? (~acc + RES_W'(1)) : acc;
      end
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Directed self-checking bench for multiplier; expected latencies follow the MUL_EARLY_OUT_EN build macro.
module tb_multiplier;

  logic        mul_clk;
  logic        resetn;
  logic        mul;
  logic        mul_signed;
  logic [31:0] x;
  logic [31:0] y;
  logic [63:0] result;
  logic        complete;

  int          n_checks;
  int          n_fails;
  logic [63:0] prev_result;

  multiplier dut (
    .mul_clk    (mul_clk),
    .resetn     (resetn),
    .mul        (mul),
    .mul_signed (mul_signed),
    .x          (x),
    .y          (y),
    .result     (result),
    .complete   (complete)
  );

  initial begin
    mul_clk = 1'b0;
    forever #5 mul_clk = ~mul_clk;
  end

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full operation: latency, product, DONE hold, and complete falling after mul drops.
  // change_at > 0 scrambles operands right after edge E<change_at>.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] exp, input int lat_early,
                       input int change_at);
    int edges;
    int lat;
    bit done;
`ifdef MUL_EARLY_OUT_EN
    lat = lat_early;
`else
    lat = 34;
`endif
    x = a; y = b; mul_signed = s; mul = 1'b1;
    edges = 0; done = 0;
    while (edges < 40 && !done) begin
      @(posedge mul_clk); #1;
      edges++;
      if (complete) done = 1;
      else check64({tag, "_result_hold"}, result, prev_result);
      if (change_at > 0 && edges == change_at + 1) begin
        x = ~a; y = 32'h0000_1234; mul_signed = ~s;
      end
    end
    check_int({tag, "_latency"}, edges, lat);
    check64({tag, "_result"}, result, exp);
    @(posedge mul_clk); #1;
    check64({tag, "_done_hold"}, {63'd0, complete}, 64'd1);
    check64({tag, "_done_result"}, result, exp);
    mul = 1'b0;
    @(posedge mul_clk); #1;
    check64({tag, "_complete_fall"}, {63'd0, complete}, 64'd0);
    check64({tag, "_idle_result"}, result, exp);
    prev_result = exp;
  endtask

  initial begin
    n_checks = 0;
    n_fails = 0;
    prev_result = 64'd0;
    resetn = 1'b0;
    mul = 1'b0;
    mul_signed = 1'b0;
    x = '0;
    y = '0;
    #1;
    check64("reset_result", result, 64'd0);
    check64("reset_complete", {63'd0, complete}, 64'd0);
    @(negedge mul_clk);
    @(negedge mul_clk);
    resetn = 1'b1;
    @(posedge mul_clk); #1;
    check64("post_reset_idle", {63'd0, complete}, 64'd0);

    do_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 34, 0);
    do_op("s_corner", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000, 3, 0);
    do_op("u_corner", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h7FFF_FFFF_8000_0000, 34, 0);
    do_op("mixed", 32'hFFFF_FFFF, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 5, 0);
    do_op("negneg", 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1, 64'h0000_0000_0000_0006, 4, 0);
    do_op("opnd_hold", 32'h0000_FFFF, 32'h0001_0001, 1'b0, 64'h0000_0000_FFFF_FFFF, 19, 5);

    // Abort: drop mul before E10
    x = 32'd5; y = 32'hFFFF_FFFF; mul_signed = 1'b0; mul = 1'b1;
    repeat (10) begin @(posedge mul_clk); #1; end
    mul = 1'b0;
    @(posedge mul_clk); #1;
    check64("abort_complete", {63'd0, complete}, 64'd0);
    check64("abort_result", result, prev_result);
    @(posedge mul_clk); #1;
    check64("abort_idle_complete", {63'd0, complete}, 64'd0);
    check64("abort_idle_result", result, prev_result);
    do_op("after_abort", 32'd3, 32'd5, 1'b0, 64'd15, 5, 0);

    // Async reset mid-CALC, between edges
    x = 32'h1234_5678; y = 32'hFFFF_FFFF; mul_signed = 1'b0; mul = 1'b1;
    repeat (6) begin @(posedge mul_clk); #1; end
    #2;
    resetn = 1'b0;
    mul = 1'b0;
    #1;
    check64("async_rst_result", result, 64'd0);
    check64("async_rst_complete", {63'd0, complete}, 64'd0);
    @(negedge mul_clk);
    resetn = 1'b1;
    prev_result = 64'd0;
    @(posedge mul_clk); #1;
    do_op("after_reset", 32'h1234_5678, 32'd3, 1'b0, 64'h0000_0000_369D_0368, 4, 0);
    do_op("zero_y", 32'hDEAD_BEEF, 32'd0, 1'b1, 64'd0, 3, 0);
    do_op("neg_small", 32'hFFFF_FFF6, 32'd10, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/multiplier.md
# multiplier

Iterative 32×32→64 shift-add multiplier, signed or unsigned, and the multiply-side companion to the CPU's iterative divider. It uses the same level-held command and `complete` handshake as the divider, so the EX stage drives both units with identical control logic. It takes one operand bit per cycle, with a sign-fix step at the end.

## Interface
Parameters: none (widths fixed at 32-bit operands, 64-bit product).
- `mul_clk`  in  1  block clock, rising edge.
- `resetn`  in  1  reset; asynchronous and active-low.
- `mul`  in  1  multiply command, level. Hold high until `complete` is seen, then drive low for ≥1 cycle.
- `mul_signed`  in  1  1 = two's-complement operands, 0 = unsigned. Sampled with operands.
- `x`  in  32  multiplicand. Sampled only at load.
- `y`  in  32  multiplier. Sampled only at load.
- `result`  out  64  product. Registered; updated only in FIX.
- `complete`  out  1  registered; high while in DONE.

## Operation
- States: IDLE, CALC, FIX, DONE. Encoding is free; a 6-bit iteration counter is used.
- IDLE, `mul`=1: load, then go to CALC with counter 0.
  - mcand = 64-bit zero-extended |x|.
  - mplier = 32-bit |y|.
  - acc = 0.
  - neg = sign(x) XOR sign(y).
- Magnitudes and sign:
  - When `mul_signed`=1: |v| = v[31] ? (~v+1) : v, taken as 32-bit unsigned. −2^31 gives 0x80000000.
  - When `mul_signed`=0: |v| = v and neg = 0.
- CALC, each edge:
  - If mplier[0], then acc += mcand, modulo 2^64.
  - Then mcand <<= 1, mplier >>= 1, counter += 1.
  - After the edge where counter reaches 32, go to FIX.
- FIX, one edge:
  - `result` ← neg ? (~acc+1) : acc.
  - Go to DONE.
- DONE:
  - `complete`=1.
  - Stay while `mul`=1.
  - On `mul`=0, go to IDLE; `complete` drops on that edge.
- Abort: `mul`=0 in CALC or FIX.
  - Go to IDLE on that edge.
  - `result` unchanged; `complete` stays 0.
- Input changes: `x`, `y`, `mul_signed` changing after load have no effect.
- Back-to-back operations: a new operation needs one IDLE cycle, i.e. `mul` low for ≥1 edge after DONE.

## Timing
- Reset values, applied on `resetn` low with no clock needed: state IDLE, counter 0, `result`=0, `complete`=0.
- Reset mid-operation discards it with no partial result.
- Deasserting reset does not start an operation by itself. The first edge after release with `mul`=1 loads.
- Latency, edge E0 being the one that samples `mul`=1 in IDLE:
  - E1–E32 are CALC.
  - E33 is FIX.
  - `result` and `complete` are valid after E33, i.e. 34 edges.
- `complete` is never high in the same cycle as a changed `result` value except after the FIX edge.
- `result` is stable throughout DONE and IDLE.

## Configuration
- `MUL_EARLY_OUT_EN` defined: CALC goes to FIX after any edge whose post-shift mplier is zero. At least one CALC edge always occurs.
  - Latency = n+2 edges, where n = max(1, index of highest set bit of |y| + 1).
  - |y|=0 gives 3 edges.
  - |y|=3 gives 4 edges.
  - |y| with bit 31 set gives 34 edges.
- Undefined: fixed 32 CALC edges for every operand; latency is always 34 edges.
- `result` values are identical in both builds.

## Test plan
- Unsigned max: `mul_signed`=0, x=y=0xFFFFFFFF.
  - `result`=0xFFFFFFFE_00000001.
  - `complete` rises after E33 and holds until `mul` drops, then falls on the next edge.
- Signed corner: `mul_signed`=1, x=0x80000000, y=0xFFFFFFFF.
  - `result`=0x00000000_80000000.
  - With the same operands and `mul_signed`=0: `result`=0x7FFFFFFF_80000000.
- Mixed sign: `mul_signed`=1, x=0xFFFFFFFF, y=7.
  - `result`=0xFFFFFFFF_FFFFFFF9.
  - Then x=0xFFFFFFFE, y=0xFFFFFFFD gives 0x00000000_00000006.
- Abort and operand hold:
  - Change x and y at E5: `result` still reflects the loaded values.
  - Separate run: drop `mul` at E10. `complete` stays 0 and `result` keeps the prior product. A following x=3, y=5 gives 15 after 34 edges.
- Async reset: pulse `resetn` low mid-CALC, between clock edges.
  - `result`=0 and `complete`=0 immediately.
  - The next operation is correct.
- Early-out, with and without `MUL_EARLY_OUT_EN`:
  - x=0x12345678, y=3: `result`=0x00000000_369D0368 after 4 edges with the macro, 34 without.
  - y=0: 3 edges with the macro, `result`=0.
